lc3_mem_ctrl: RTL and testbench
===============================

// Module: lc3_mem_ctrl
// PURPOSE
//  Parametrised successor to the processor's flat MAR/MDR memory: owns MAR, MDR, on-chip RAM and the
//  LC-3 memory-mapped I/O registers (KBSR/KBDR/DSR/DDR). Accesses take a configurable number of wait
//  states and are acknowledged by a ready pulse R, which the control FSM polls in its memory states.
//  Sits on the shared Bus beside the PC, ALU and MARMux drivers; MDROut feeds the Bus tri-state buffer.
// PARAMETERS
//  WIDTH        16       data/address width of Bus, MAR, MDR
//  ADDR_BITS    10       RAM depth = 2**ADDR_BITS words; RAM indexed by MAR[ADDR_BITS-1:0] (aliases)
//  WAIT_STATES  2        cycles spent in WAIT per access (0 allowed)
//  MMIO_BASE    16'hFE00 KBSR=BASE, KBDR=BASE+2, DSR=BASE+4, DDR=BASE+6; these never reach RAM
// PORTS
//  clk       in   1      clock, rising edge
//  reset     in   1      asynchronous, active-low
//  Bus       in   WIDTH  processor bus
//  ldMAR     in   1      MAR <= Bus (IDLE only)
//  ldMDR     in   1      MDR <= Bus (IDLE only; selMDR=0 path)
//  memEN     in   1      start access at MAR
//  memWE     in   1      with memEN: write MDR to MAR; else read
//  R         out  1      one-cycle access-complete pulse
//  MAROut    out  WIDTH  MAR contents
//  MDROut    out  WIDTH  MDR contents
//  kb_valid  in   1      keyboard character offered
//  kb_data   in   8      keyboard character
//  kb_ready  out  1      = ~KBSR[15]; char accepted when kb_valid & kb_ready
//  dsp_valid out  1      display character pending
//  dsp_data  out  8      display character
//  dsp_ready in   1      display consumes when dsp_valid & dsp_ready
//  irq       out  1      (KBSR[14]&KBSR[15]) | (DSR[14]&DSR[15]), registered
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, MAR=0, MDR=0, R=0, KBSR=0, KBDR=0, DSR=16'h8000, dsp_valid=0,
//   dsp_data=0, irq=0, wait counter=0. RAM contents undefined, not cleared. Access in flight is aborted: no write.
//  FSM: IDLE -memEN-> WAIT (WAIT_STATES>0) or DONE (WAIT_STATES=0); WAIT counts WAIT_STATES cycles -> DONE;
//   DONE -> IDLE unconditionally. Op (read/write) and address are captured from memWE/MAR on entry.
//  In DONE: read -> MDR <= RAM/MMIO data at captured address; write -> target <= MDR. R=1 on the
//   registered DONE output, i.e. R rises WAIT_STATES+1 cycles after the edge sampling memEN.
//  memEN, ldMAR, ldMDR ignored outside IDLE. ldMDR and memEN read in same IDLE cycle: ldMDR wins, access not started.
//  MMIO reads: KBSR={KBSR[15:14],14'b0}; KBDR={8'b0,kbd}; DSR={DSR[15:14],14'b0}; DDR reads 0.
//  MMIO writes: KBSR/DSR write only bit 14 (interrupt enable); KBDR write ignored.
//  Keyboard: on kb_valid&kb_ready, KBDR<=kb_data, KBSR[15]<=1. Read of KBDR in DONE clears KBSR[15].
//   No accept/clear collision possible (kb_ready=0 while KBSR[15]=1).
//  Display: write of DDR in DONE with DSR[15]=1 -> dsp_data<=MDR[7:0], dsp_valid<=1, DSR[15]<=0.
//   Write of DDR while DSR[15]=0 is dropped. dsp_valid&dsp_ready -> dsp_valid<=0, DSR[15]<=1 same edge.
//  Address compare uses full WIDTH bits of captured MAR; all other addresses go to RAM (low bits).
//  irq registered from next-state status bits, so it tracks flag changes with no extra cycle.
// TESTING
//  1 Reset mid-WAIT of write MAR=16'h0010, MDR=16'hBEEF -> R never pulses; later read of 0x0010 != BEEF
//    path untouched (prior value returned); DSR reads 16'h8000.
//  2 WAIT_STATES=2: write 16'h1234 to 0x0005, read back -> R exactly 3 cycles after memEN edge each time,
//    MDROut=16'h1234; address 0x0405 (ADDR_BITS=10) returns 16'h1234 (alias).
//  3 kb_valid=1, kb_data=8'h41 -> kb_ready drops next cycle; read KBSR=16'h8000, read KBDR=16'h0041,
//    then KBSR=16'h0000 and kb_ready=1.
//  4 Write KBSR=16'h4000, then offer char -> irq=1 same cycle KBSR[15] sets; read KBDR -> irq=0.
//  5 dsp_ready=0; write DDR=16'h0058 -> dsp_valid=1, dsp_data=8'h58, DSR=16'h0000; second write 16'h0059
//    dropped; dsp_ready=1 -> dsp_valid=0, DSR=16'h8000, dsp_data stays 8'h58.
//  6 WAIT_STATES=0: memEN held high 4 cycles -> accesses start on every other cycle (IDLE,DONE alternation);
//    ldMAR pulsed during DONE -> MAR unchanged.

Source files
------------

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: MAR/MDR, on-chip RAM with configurable wait states,
// and the KBSR/KBDR/DSR/DDR memory-mapped keyboard and display registers.
module lc3_mem_ctrl #(
    parameter int                WIDTH       = 16,
    parameter int                ADDR_BITS   = 10,
    parameter int                WAIT_STATES = 2,
    parameter logic [WIDTH-1:0]  MMIO_BASE   = 16'hFE00
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] Bus,
    input  logic             ldMAR,
    input  logic             ldMDR,
    input  logic             memEN,
    input  logic             memWE,
    output logic             R,
    output logic [WIDTH-1:0] MAROut,
    output logic [WIDTH-1:0] MDROut,
    input  logic             kb_valid,
    input  logic [7:0]       kb_data,
    output logic             kb_ready,
    output logic             dsp_valid,
    output logic [7:0]       dsp_data,
    input  logic             dsp_ready,
    output logic             irq
);

    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] CNT_LAST = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    localparam logic [WIDTH-1:0] KBSR_ADDR = MMIO_BASE;
    localparam logic [WIDTH-1:0] KBDR_ADDR = MMIO_BASE + WIDTH'(2);
    localparam logic [WIDTH-1:0] DSR_ADDR  = MMIO_BASE + WIDTH'(4);
    localparam logic [WIDTH-1:0] DDR_ADDR  = MMIO_BASE + WIDTH'(6);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    wait_cnt, wait_cnt_nxt;
    logic             start;

    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] cap_addr;
    logic             cap_we;
    logic             r_q;

    logic [WIDTH-1:0] mem [2**ADDR_BITS];
    logic [ADDR_BITS-1:0] ram_idx;

    logic             kb_full, kb_ie, dsr_rdy, dsr_ie;
    logic [7:0]       kbd;
    logic             dsp_valid_q;
    logic [7:0]       dsp_data_q;
    logic             irq_q;

    logic             kb_full_nxt, kb_ie_nxt, dsr_rdy_nxt, dsr_ie_nxt;
    logic [7:0]       kbd_nxt;
    logic             dsp_valid_nxt;
    logic [7:0]       dsp_data_nxt;

    logic             in_done;
    logic             is_kbsr, is_kbdr, is_dsr, is_ddr, is_ram;
    logic             ram_we;
    logic [WIDTH-1:0] rd_data;

    assign in_done = (state == ST_DONE);
    assign ram_idx = cap_addr[ADDR_BITS-1:0];
    assign is_kbsr = (cap_addr == KBSR_ADDR);
    assign is_kbdr = (cap_addr == KBDR_ADDR);
    assign is_dsr  = (cap_addr == DSR_ADDR);
    assign is_ddr  = (cap_addr == DDR_ADDR);
    assign is_ram  = ~(is_kbsr | is_kbdr | is_dsr | is_ddr);
    assign ram_we  = in_done & cap_we & is_ram;

    // Access sequencing; ldMDR takes priority over memEN in the same IDLE cycle.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        start        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memEN && !ldMDR) begin
                    start        = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == CNT_LAST) begin
                    wait_cnt_nxt = '0;
                    state_nxt    = ST_DONE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (is_kbsr) begin
            rd_data[WIDTH-1] = kb_full;
            rd_data[WIDTH-2] = kb_ie;
        end else if (is_kbdr) begin
            rd_data[7:0] = kbd;
        end else if (is_dsr) begin
            rd_data[WIDTH-1] = dsr_rdy;
            rd_data[WIDTH-2] = dsr_ie;
        end else if (is_ram) begin
            rd_data = mem[ram_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            mar      <= '0;
            mdr      <= '0;
            cap_addr <= '0;
            cap_we   <= 1'b0;
            r_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            r_q      <= in_done;
            if (state == ST_IDLE) begin
                if (ldMAR) begin
                    mar <= Bus;
                end
                if (ldMDR) begin
                    mdr <= Bus;
                end
            end
            if (start) begin
                cap_addr <= mar;
                cap_we   <= memWE;
            end
            if (in_done && !cap_we) begin
                mdr <= rd_data;
            end
        end
    end

    // RAM has no reset; its contents are undefined after power-up.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= mdr;
        end
    end

    always_comb begin
        kb_full_nxt   = kb_full;
        kb_ie_nxt     = kb_ie;
        kbd_nxt       = kbd;
        dsr_rdy_nxt   = dsr_rdy;
        dsr_ie_nxt    = dsr_ie;
        dsp_valid_nxt = dsp_valid_q;
        dsp_data_nxt  = dsp_data_q;
        if (kb_valid && !kb_full) begin
            kbd_nxt     = kb_data;
            kb_full_nxt = 1'b1;
        end
        if (dsp_valid_q && dsp_ready) begin
            dsp_valid_nxt = 1'b0;
            dsr_rdy_nxt   = 1'b1;
        end
        // Status registers only accept the interrupt-enable bit from software.
        if (in_done) begin
            if (cap_we) begin
                if (is_kbsr) begin
                    kb_ie_nxt = mdr[WIDTH-2];
                end
                if (is_dsr) begin
                    dsr_ie_nxt = mdr[WIDTH-2];
                end
                if (is_ddr && dsr_rdy) begin
                    dsp_data_nxt  = mdr[7:0];
                    dsp_valid_nxt = 1'b1;
                    dsr_rdy_nxt   = 1'b0;
                end
            end else if (is_kbdr) begin
                kb_full_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_full     <= 1'b0;
            kb_ie       <= 1'b0;
            kbd         <= '0;
            dsr_rdy     <= 1'b1;
            dsr_ie      <= 1'b0;
            dsp_valid_q <= 1'b0;
            dsp_data_q  <= '0;
            irq_q       <= 1'b0;
        end else begin
            kb_full     <= kb_full_nxt;
            kb_ie       <= kb_ie_nxt;
            kbd         <= kbd_nxt;
            dsr_rdy     <= dsr_rdy_nxt;
            dsr_ie      <= dsr_ie_nxt;
            dsp_valid_q <= dsp_valid_nxt;
            dsp_data_q  <= dsp_data_nxt;
            irq_q       <= (kb_full_nxt & kb_ie_nxt) | (dsr_rdy_nxt & dsr_ie_nxt);
        end
    end

    assign R         = r_q;
    assign MAROut    = mar;
    assign MDROut    = mdr;
    assign kb_ready  = ~kb_full;
    assign dsp_valid = dsp_valid_q;
    assign dsp_data  = dsp_data_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: a WAIT_STATES=2 instance driven with
// directed and random accesses against a behavioural memory/MMIO model, plus a WAIT_STATES=0 instance.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [15:0] Bus;
    logic        ldMAR, ldMDR, memEN, memWE;
    logic        R;
    logic [15:0] MAROut, MDROut;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        irq;

    logic [15:0] bus0;
    logic        ldMAR0, ldMDR0, memEN0, memWE0;
    logic        r0;
    logic [15:0] mar_out0, mdr_out0;
    logic        kb_valid0, dsp_ready0;
    logic [7:0]  kb_data0;
    logic        kb_ready0, dsp_valid0, irq0;
    logic [7:0]  dsp_data0;

    int checks = 0;
    int passes = 0;

    logic [15:0] model_mem [1024];
    bit          model_valid [1024];

    lc3_mem_ctrl #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(2), .MMIO_BASE(16'hFE00)) dut (
        .clk(clk), .reset(reset), .Bus(Bus), .ldMAR(ldMAR), .ldMDR(ldMDR),
        .memEN(memEN), .memWE(memWE), .R(R), .MAROut(MAROut), .MDROut(MDROut),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready), .irq(irq)
    );

    lc3_mem_ctrl #(.WIDTH(16), .ADDR_BITS(10), .WAIT_STATES(0), .MMIO_BASE(16'hFE00)) dut0 (
        .clk(clk), .reset(reset), .Bus(bus0), .ldMAR(ldMAR0), .ldMDR(ldMDR0),
        .memEN(memEN0), .memWE(memWE0), .R(r0), .MAROut(mar_out0), .MDROut(mdr_out0),
        .kb_valid(kb_valid0), .kb_data(kb_data0), .kb_ready(kb_ready0),
        .dsp_valid(dsp_valid0), .dsp_data(dsp_data0), .dsp_ready(dsp_ready0), .irq(irq0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads MAR (and MDR for writes), pulses memEN, then waits a bounded time for R.
    task automatic do_access(input logic [15:0] addr, input logic [15:0] data, input logic we,
                             output int lat, output logic [15:0] rdata);
        Bus = addr; ldMAR = 1'b1; step(); ldMAR = 1'b0;
        if (we) begin
            Bus = data; ldMDR = 1'b1; step(); ldMDR = 1'b0;
        end
        memWE = we; memEN = 1'b1; step(); memEN = 1'b0; memWE = 1'b0;
        lat = -1;
        rdata = 'x;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (R === 1'b1) begin
                lat = i;
                rdata = MDROut;
                break;
            end
        end
        if (we) model_write(addr, data);
    endtask

    function automatic void model_write(input logic [15:0] addr, input logic [15:0] data);
        if (addr < 16'hFE00 || addr > 16'hFE06) begin
            model_mem[addr % 1024] = data;
            model_valid[addr % 1024] = 1'b1;
        end
    endfunction

    task automatic test_reset();
        int lat;
        logic [15:0] rd;
        bit r_seen;
        checks++; if (R !== 1'b0) $display("[TB] FAIL reset_R got %b expected 0", R); else passes++;
        checks++; if (MAROut !== 16'h0) $display("[TB] FAIL reset_MAR got %h expected 0000", MAROut); else passes++;
        checks++; if (MDROut !== 16'h0) $display("[TB] FAIL reset_MDR got %h expected 0000", MDROut); else passes++;
        checks++; if (kb_ready !== 1'b1) $display("[TB] FAIL reset_kb_ready got %b expected 1", kb_ready); else passes++;
        checks++; if (dsp_valid !== 1'b0 || dsp_data !== 8'h0) $display("[TB] FAIL reset_dsp got %b/%h expected 0/00", dsp_valid, dsp_data); else passes++;
        checks++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq got %b expected 0", irq); else passes++;
        reset = 1'b1;
        step();
        do_access(16'h0010, 16'h1111, 1'b1, lat, rd);
        checks++; if (lat !== 3) $display("[TB] FAIL pre_write_latency got %0d expected 3", lat); else passes++;
        // Abort a write of BEEF while it sits in WAIT.
        Bus = 16'h0010; ldMAR = 1'b1; step(); ldMAR = 1'b0;
        Bus = 16'hBEEF; ldMDR = 1'b1; step(); ldMDR = 1'b0;
        memWE = 1'b1; memEN = 1'b1; step(); memEN = 1'b0; memWE = 1'b0;
        step();
        reset = 1'b0;
        #2;
        checks++; if (MDROut !== 16'h0 || MAROut !== 16'h0) $display("[TB] FAIL async_reset got MAR %h MDR %h expected 0000/0000", MAROut, MDROut); else passes++;
        r_seen = 1'b0;
        repeat (3) begin
            step();
            if (R === 1'b1) r_seen = 1'b1;
        end
        reset = 1'b1;
        repeat (5) begin
            step();
            if (R === 1'b1) r_seen = 1'b1;
        end
        checks++; if (r_seen !== 1'b0) $display("[TB] FAIL abort_no_R got %b expected 0", r_seen); else passes++;
        do_access(16'h0010, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== model_mem[16]) $display("[TB] FAIL abort_no_write got %h expected %h", rd, model_mem[16]); else passes++;
        do_access(16'hFE04, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h8000) $display("[TB] FAIL reset_DSR got %h expected 8000", rd); else passes++;
    endtask

    task automatic test_ram_alias();
        int lat;
        logic [15:0] rd;
        do_access(16'h0005, 16'h1234, 1'b1, lat, rd);
        checks++; if (lat !== 3) $display("[TB] FAIL write_latency got %0d expected 3", lat); else passes++;
        step();
        checks++; if (R !== 1'b0) $display("[TB] FAIL R_one_cycle got %b expected 0", R); else passes++;
        do_access(16'h0005, 16'h0, 1'b0, lat, rd);
        checks++; if (lat !== 3) $display("[TB] FAIL read_latency got %0d expected 3", lat); else passes++;
        checks++; if (rd !== 16'h1234) $display("[TB] FAIL readback got %h expected 1234", rd); else passes++;
        do_access(16'h0405, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h1234) $display("[TB] FAIL alias_read got %h expected 1234", rd); else passes++;
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] rd, addr, data;
        logic we;
        for (int n = 0; n < 40; n++) begin
            addr = 16'($urandom_range(0, 16'hFDFF));
            if (n % 3 == 2) addr = {6'($urandom), 10'(n * 37)};
            if (addr >= 16'hFE00 && addr <= 16'hFE07) addr = 16'h0100;
            data = 16'($urandom);
            we = (n < 8) ? 1'b1 : 1'($urandom);
            if (!we && !model_valid[addr % 1024]) we = 1'b1;
            do_access(addr, data, we, lat, rd);
            checks++; if (lat !== 3) $display("[TB] FAIL rand_latency op %0d got %0d expected 3", n, lat); else passes++;
            if (!we) begin
                checks++;
                if (rd !== model_mem[addr % 1024]) $display("[TB] FAIL rand_read addr %h got %h expected %h", addr, rd, model_mem[addr % 1024]);
                else passes++;
            end
        end
    endtask

    task automatic test_keyboard();
        int lat;
        logic [15:0] rd;
        kb_data = 8'h41; kb_valid = 1'b1; step(); kb_valid = 1'b0;
        checks++; if (kb_ready !== 1'b0) $display("[TB] FAIL kb_ready_drop got %b expected 0", kb_ready); else passes++;
        do_access(16'hFE00, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h8000) $display("[TB] FAIL KBSR_full got %h expected 8000", rd); else passes++;
        do_access(16'hFE02, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h0041) $display("[TB] FAIL KBDR got %h expected 0041", rd); else passes++;
        do_access(16'hFE00, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h0000) $display("[TB] FAIL KBSR_clear got %h expected 0000", rd); else passes++;
        checks++; if (kb_ready !== 1'b1) $display("[TB] FAIL kb_ready_back got %b expected 1", kb_ready); else passes++;
    endtask

    task automatic test_irq();
        int lat;
        logic [15:0] rd;
        do_access(16'hFE00, 16'h4000, 1'b1, lat, rd);
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_idle got %b expected 0", irq); else passes++;
        kb_data = 8'h7A; kb_valid = 1'b1; step(); kb_valid = 1'b0;
        checks++; if (irq !== 1'b1 || kb_ready !== 1'b0) $display("[TB] FAIL irq_set got irq %b kb_ready %b expected 1/0", irq, kb_ready); else passes++;
        do_access(16'hFE00, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'hC000) $display("[TB] FAIL KBSR_ie_full got %h expected C000", rd); else passes++;
        do_access(16'hFE02, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h007A) $display("[TB] FAIL KBDR_irq got %h expected 007A", rd); else passes++;
        checks++; if (irq !== 1'b0) $display("[TB] FAIL irq_clear got %b expected 0", irq); else passes++;
        do_access(16'hFE00, 16'h0, 1'b1, lat, rd);
    endtask

    task automatic test_display();
        int lat;
        logic [15:0] rd;
        dsp_ready = 1'b0;
        do_access(16'hFE06, 16'h0058, 1'b1, lat, rd);
        checks++; if (dsp_valid !== 1'b1 || dsp_data !== 8'h58) $display("[TB] FAIL ddr_write got %b/%h expected 1/58", dsp_valid, dsp_data); else passes++;
        do_access(16'hFE04, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h0000) $display("[TB] FAIL DSR_busy got %h expected 0000", rd); else passes++;
        do_access(16'hFE06, 16'h0059, 1'b1, lat, rd);
        checks++; if (dsp_data !== 8'h58) $display("[TB] FAIL ddr_drop got %h expected 58", dsp_data); else passes++;
        do_access(16'hFE06, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h0000) $display("[TB] FAIL DDR_read got %h expected 0000", rd); else passes++;
        dsp_ready = 1'b1; step(); dsp_ready = 1'b0;
        checks++; if (dsp_valid !== 1'b0) $display("[TB] FAIL dsp_consume got %b expected 0", dsp_valid); else passes++;
        do_access(16'hFE04, 16'h0, 1'b0, lat, rd);
        checks++; if (rd !== 16'h8000) $display("[TB] FAIL DSR_ready got %h expected 8000", rd); else passes++;
        checks++; if (dsp_data !== 8'h58) $display("[TB] FAIL dsp_data_hold got %h expected 58", dsp_data); else passes++;
    endtask

    task automatic test_zero_wait();
        logic exp_r [5];
        exp_r = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bus0 = 16'h0020; ldMAR0 = 1'b1; step(); ldMAR0 = 1'b0;
        memEN0 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin
                bus0 = 16'h0333; ldMAR0 = 1'b1;
            end
            if (c == 4) memEN0 = 1'b0;
            step();
            ldMAR0 = 1'b0;
            checks++;
            if (r0 !== exp_r[c]) $display("[TB] FAIL zero_wait_R cycle %0d got %b expected %b", c, r0, exp_r[c]);
            else passes++;
        end
        checks++; if (mar_out0 !== 16'h0020) $display("[TB] FAIL ldMAR_in_DONE got %h expected 0020", mar_out0); else passes++;
    endtask

    initial begin
        reset = 1'b0;
        Bus = '0; ldMAR = 0; ldMDR = 0; memEN = 0; memWE = 0;
        kb_valid = 0; kb_data = '0; dsp_ready = 0;
        bus0 = '0; ldMAR0 = 0; ldMDR0 = 0; memEN0 = 0; memWE0 = 0;
        kb_valid0 = 0; kb_data0 = '0; dsp_ready0 = 0;
        for (int i = 0; i < 1024; i++) model_valid[i] = 1'b0;
        step(); step();
        test_reset();
        test_ram_alias();
        test_random();
        test_keyboard();
        test_irq();
        test_display();
        test_zero_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
